// File: rtl/blink_meter_pkg.sv
// blink_meter_pkg: FSM state encoding and default sizing for the blink period meter.
package blink_meter_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, TIMEOUT} state_t;
    localparam int CNT_W_DEF = 27;
    localparam int MAX_PERIOD_DEF = 40000000;
endpackage

// File: rtl/blink_period_meter_if.sv
// blink_period_meter_if: result handshake and status bundle of the blink period meter.
interface blink_period_meter_if import blink_meter_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    logic meas_valid;
    logic meas_ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic overrun;
    logic stalled;
    modport master (output meas_valid, period, high_time, overrun, stalled, input meas_ready);
    modport slave (input meas_valid, period, high_time, overrun, stalled, output meas_ready);
endinterface

// File: rtl/blink_debounce.sv
// blink_debounce: 2-flop synchronizer, plus a stability filter when BLINK_METER_DEBOUNCE_EN is defined.
module blink_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic s1, s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end
`ifdef BLINK_METER_DEBOUNCE_EN
    localparam int W = $clog2(DEB_CYCLES + 1);
    logic [W-1:0] cnt;
    // cnt counts consecutive samples that disagree with the filtered output
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dout <= 1'b0;
        end else if (s2 == dout) begin
            cnt <= '0;
        end else if (cnt == W'(DEB_CYCLES - 1)) begin
            cnt <= '0;
            dout <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign dout = s2;
`endif
endmodule

// File: rtl/blink_period_meter.sv
// blink_period_meter: measures period and high time between rising edges of an async blink line.
// Optional input debounce filter is enabled by defining BLINK_METER_DEBOUNCE_EN.
module blink_period_meter import blink_meter_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MAX_PERIOD = MAX_PERIOD_DEF,
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic blink_in,
    blink_period_meter_if.master m
);
    logic f, f_d, rise;
    state_t state;
    logic [CNT_W-1:0] period_cnt, high_cnt;
    blink_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk(clk),
        .rst(rst),
        .din(blink_in),
        .dout(f)
    );
    assign rise = f & ~f_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            f_d <= 1'b0;
            period_cnt <= '0;
            high_cnt <= '0;
            m.meas_valid <= 1'b0;
            m.period <= '0;
            m.high_time <= '0;
            m.overrun <= 1'b0;
            m.stalled <= 1'b0;
        end else begin
            f_d <= f;
            if (m.meas_valid && m.meas_ready) m.meas_valid <= 1'b0;
            case (state)
                IDLE: state <= ARMED;
                ARMED, TIMEOUT: begin
                    if (rise) begin
                        state <= MEASURE;
                        period_cnt <= CNT_W'(1);
                        high_cnt <= CNT_W'(1);
                        m.stalled <= 1'b0;
                    end
                end
                MEASURE: begin
                    // a capture takes priority over the handshake clear above
                    if (rise) begin
                        m.period <= period_cnt;
                        m.high_time <= high_cnt;
                        m.meas_valid <= 1'b1;
                        m.overrun <= m.overrun | (m.meas_valid & ~m.meas_ready);
                        period_cnt <= CNT_W'(1);
                        high_cnt <= CNT_W'(1);
                    end else if (period_cnt >= CNT_W'(MAX_PERIOD)) begin
                        state <= TIMEOUT;
                        m.stalled <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                        high_cnt <= high_cnt + CNT_W'(f);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blink_period_meter.sv
// tb_blink_period_meter: directed scoreboard bench for blink_period_meter (MAX_PERIOD=1000).
module tb_blink_period_meter;
    import blink_meter_pkg::*;
`ifdef BLINK_METER_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif
    typedef struct {
        logic [26:0] p;
        logic [26:0] h;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic blink_in = 1'b0;
    int errors = 0;
    int checks = 0;
    res_t q[$];
    blink_period_meter_if #(.CNT_W(27)) bus ();
    blink_period_meter #(.CNT_W(27), .MAX_PERIOD(1000), .DEB_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .blink_in(blink_in),
        .m(bus.master)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic push(input int p, input int h);
        q.push_back('{27'(p), 27'(h)});
    endtask
    // every accepted result is matched against the oldest expected one
    always @(negedge clk) begin
        if (!rst && bus.meas_valid && bus.meas_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed period=%0d with no expected result", bus.period);
            end
            if (q.size() != 0) begin
                res_t e;
                e = q.pop_front();
                chk("sb_period", 64'(bus.period), 64'(e.p));
                chk("sb_high_time", 64'(bus.high_time), 64'(e.h));
            end
        end
    end
    initial begin
        int n;
        logic saw;
        bus.meas_ready = 1'b1;
        cyc(3);
        chk("rst_valid", 64'(bus.meas_valid), 0);
        chk("rst_period", 64'(bus.period), 0);
        chk("rst_high", 64'(bus.high_time), 0);
        chk("rst_overrun", 64'(bus.overrun), 0);
        chk("rst_stalled", 64'(bus.stalled), 0);
        rst = 1'b0;
        cyc(2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) push(100, 30);
            blink_in = 1'b1;
            cyc(30);
            blink_in = 1'b0;
            cyc(70);
        end
        chk("sq_drained", 64'(q.size()), 0);
        chk("sq_overrun", 64'(bus.overrun), 0);
        push(100, 30);
        blink_in = 1'b1;
        cyc(25);
        bus.meas_ready = 1'b0;
        cyc(5);
        blink_in = 1'b0;
        cyc(50);
        push(80, 30);
        blink_in = 1'b1;
        cyc(45);
        blink_in = 1'b0;
        cyc(15);
        blink_in = 1'b1;
        cyc(LAT - 1);
        bus.meas_ready = 1'b1;
        cyc(1);
        bus.meas_ready = 1'b0;
        cyc(2);
        chk("hs_cap_valid", 64'(bus.meas_valid), 1);
        chk("hs_cap_period", 64'(bus.period), 60);
        chk("hs_cap_high", 64'(bus.high_time), 45);
        chk("hs_cap_overrun", 64'(bus.overrun), 0);
        chk("hs_cap_drained", 64'(q.size()), 0);
        cyc(28 - LAT);
        blink_in = 1'b0;
        cyc(70);
        blink_in = 1'b1;
        cyc(LAT + 3);
        chk("ovr_valid", 64'(bus.meas_valid), 1);
        chk("ovr_period", 64'(bus.period), 100);
        chk("ovr_high", 64'(bus.high_time), 30);
        chk("ovr_overrun", 64'(bus.overrun), 1);
        push(100, 30);
        bus.meas_ready = 1'b1;
        cyc(1);
        bus.meas_ready = 1'b0;
        chk("ovr_valid_drop", 64'(bus.meas_valid), 0);
        chk("ovr_drained", 64'(q.size()), 0);
        cyc(26 - LAT);
        blink_in = 1'b0;
        cyc(20);
        rst = 1'b1;
        bus.meas_ready = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        chk("to_overrun_cleared", 64'(bus.overrun), 0);
        blink_in = 1'b1;
        n = 0;
        saw = 1'b0;
        while (!bus.stalled && n < 1100 + LAT) begin
            cyc(1);
            n++;
            if (bus.meas_valid) saw = 1'b1;
        end
        chk("to_stall_delay", 64'(n), 64'(1000 + LAT));
        chk("to_no_result", 64'(saw), 0);
        blink_in = 1'b0;
        cyc(50);
        blink_in = 1'b1;
        cyc(LAT + 3);
        chk("to_unstall", 64'(bus.stalled), 0);
        cyc(97 - LAT);
        blink_in = 1'b0;
        cyc(100);
        push(200, 100);
        blink_in = 1'b1;
        cyc(LAT + 3);
        chk("to_drained", 64'(q.size()), 0);
        chk("to_period", 64'(bus.period), 200);
        chk("to_stalled", 64'(bus.stalled), 0);
        cyc(27 - LAT);
        blink_in = 1'b0;
        cyc(20);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_valid", 64'(bus.meas_valid), 0);
        chk("mid_rst_period", 64'(bus.period), 0);
        chk("mid_rst_high", 64'(bus.high_time), 0);
        chk("mid_rst_stalled", 64'(bus.stalled), 0);
        rst = 1'b0;
        cyc(50);
        blink_in = 1'b1;
        cyc(LAT + 3);
        chk("mid_rst_first_edge", 64'(bus.meas_valid), 0);
        cyc(27 - LAT);
        blink_in = 1'b0;
        cyc(70);
        push(100, 30);
        blink_in = 1'b1;
        cyc(LAT + 3);
        chk("mid_rst_drained", 64'(q.size()), 0);
        chk("mid_rst_period2", 64'(bus.period), 100);
        chk("mid_rst_high2", 64'(bus.high_time), 30);
`ifdef BLINK_METER_DEBOUNCE_EN
        cyc(197 - LAT);
        blink_in = 1'b0;
        cyc(100);
        blink_in = 1'b1;
        cyc(5);
        blink_in = 1'b0;
        cyc(95);
        push(400, 200);
        blink_in = 1'b1;
        cyc(200);
        blink_in = 1'b0;
        cyc(100);
        push(300, 200);
        blink_in = 1'b1;
        cyc(20);
        blink_in = 1'b0;
        cyc(80);
        push(100, 20);
        blink_in = 1'b1;
        cyc(LAT + 3);
        chk("deb_drained", 64'(q.size()), 0);
`endif
        blink_in = 1'b0;
        cyc(10);
        chk("final_drained", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
